iic_adc_slave: RTL and testbench

IIC_ADC_SLAVE -- requirements
Module: iic_adc_slave

---
 rtl/iic_pkg.sv | 25 ++
 rtl/iic_edge_sync.sv | 61 ++++++
 rtl/iic_adc_slave.sv | 214 +++++++++++++++++++++
 tb/tb_iic_adc_slave.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared types and constants for the PCF8591-style I2C ADC/DAC slave.
package iic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic [6:0]  PCF8591_ADDR = 7'h48;
    localparam int unsigned CTRL_CH_LSB  = 0;
    localparam int unsigned CTRL_CH_MSB  = 1;
    localparam int unsigned CTRL_AUTOINC = 2;
    localparam logic [7:0]  CONV_RESET   = 8'h80;

    function automatic logic [7:0] ch_select(input logic [31:0] data, input logic [1:0] ch);
        ch_select = data[{ch, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/iic_edge_sync.sv
// Two-flop synchronizer plus a run-length glitch filter for one I2C line.
// The filtered level flips only after FILT_LEN consecutive differing samples.
module iic_edge_sync #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Idle bus is high, so every flop comes out of reset at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                level_d = sync_q;
                rise_d  = sync_q;
                fall_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/iic_adc_slave.sv
// I2C slave modelled on the PCF8591: control/DAC writes and ADC channel reads.
// All bus decoding runs on filtered SCL/SDA levels and their edge flags.
module iic_adc_slave
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = PCF8591_ADDR,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [31:0] ch_data,
    output logic [7:0]  ctrl_reg,
    output logic [7:0]  dac_data,
    output logic        dac_wr,
    output logic        busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start, stop;

    iic_edge_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (scl_i),
        .level_o (scl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    iic_edge_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (sda_i),
        .level_o (sda),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start = sda_fall & scl;
    assign stop  = sda_rise & scl;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       first_q, first_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] dac_q, dac_d;
    logic       dac_wr_q, dac_wr_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] conv_q, conv_d;
    logic [1:0] chan_q, chan_d;

    logic [7:0] wr_byte;
    logic [7:0] ch_byte;
    logic       addr_match;

    assign wr_byte    = {rx_q[6:0], sda};
    assign ch_byte    = ch_select(ch_data, chan_q);
    assign addr_match = (rx_q[7:1] == DEV_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            first_q   <= 1'b0;
            ctrl_q    <= '0;
            dac_q     <= '0;
            dac_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            conv_q    <= CONV_RESET;
            chan_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            first_q   <= first_d;
            ctrl_q    <= ctrl_d;
            dac_q     <= dac_d;
            dac_wr_q  <= dac_wr_d;
            busy_q    <= busy_d;
            sda_oe_q  <= sda_oe_d;
            conv_q    <= conv_d;
            chan_q    <= chan_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:     if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) state_d = rx_q[0] ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (scl_fall && bit_cnt_q == 4'd8) state_d = WR_ACK;
                WR_ACK:   if (scl_fall) state_d = WR_BYTE;
                RD_BYTE:  if (scl_fall && bit_cnt_q == 4'd8) state_d = RD_ACK;
                RD_ACK:   if (scl_rise) state_d = sda ? IGNORE : RD_BYTE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        first_d   = first_q;
        ctrl_d    = ctrl_q;
        dac_d     = dac_q;
        dac_wr_d  = 1'b0;
        busy_d    = busy_q;
        sda_oe_d  = sda_oe_q;
        conv_d    = conv_q;
        chan_d    = chan_q;
        if (stop) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        rx_d      = wr_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = addr_match;
                        busy_d   = addr_match;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        first_d   = ~rx_q[0];
                        if (rx_q[0]) begin
                            sda_oe_d = ~conv_q[7];
                            tx_d     = {conv_q[6:0], 1'b0};
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        rx_d      = wr_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit on the 8th rising edge so a STOP straight after a full byte keeps it.
                        if (bit_cnt_q == 4'd7) begin
                            if (first_q) begin
                                ctrl_d  = wr_byte;
                                chan_d  = wr_byte[CTRL_CH_MSB:CTRL_CH_LSB];
                                first_d = 1'b0;
                            end else begin
                                dac_d    = wr_byte;
                                dac_wr_d = 1'b1;
                            end
                        end
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) sda_oe_d = 1'b1;
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
                    // Entered either with bit7 already driven (after address) or undriven (after master ACK).
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        conv_d    = ch_byte;
                        bit_cnt_d = '0;
                        if (ctrl_q[CTRL_AUTOINC]) chan_d = chan_q + 2'd1;
                        if (!sda) tx_d = ch_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign ctrl_reg = ctrl_q;
    assign dac_data = dac_q;
    assign dac_wr   = dac_wr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_iic_adc_slave.sv
// Self-checking bench for iic_adc_slave: bit-banged I2C master plus a
// transaction-level model of the control/DAC/conversion registers.
module tb_iic_adc_slave;
    import iic_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m;
    logic        scl_i, sda_i;
    logic        sda_oe;
    logic [31:0] ch_data;
    logic [7:0]  ctrl_reg, dac_data;
    logic        dac_wr, busy;

    int nchecks = 0;
    int nfail   = 0;

    logic [7:0] m_ctrl, m_dac, m_conv;
    int         m_chan;

    int dac_pulses, dac_maxw, dac_run;
    int oe_bad, oe_on;
    logic oe_prev;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    iic_adc_slave #(.DEV_ADDR(7'h48), .FILT_LEN(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .ch_data  (ch_data),
        .ctrl_reg (ctrl_reg),
        .dac_data (dac_data),
        .dac_wr   (dac_wr),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (dac_wr === 1'b1) begin
            dac_run = dac_run + 1;
            if (dac_run == 1) dac_pulses = dac_pulses + 1;
            if (dac_run > dac_maxw) dac_maxw = dac_run;
        end else begin
            dac_run = 0;
        end
        if (rst) begin
            oe_prev = 1'b0;
        end else begin
            if (sda_oe !== oe_prev && scl_m) oe_bad = oe_bad + 1;
            if (sda_oe === 1'b1) oe_on = oe_on + 1;
            oe_prev = sda_oe;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] chan_val(input logic [31:0] d, input int ch);
        chan_val = 8'((d >> (8 * ch)) & 32'hFF);
    endfunction

    task automatic model_reset();
        m_ctrl = 8'h00;
        m_dac  = 8'h00;
        m_conv = 8'h80;
        m_chan = 0;
    endtask

    task automatic model_write(input logic [7:0] b, input bit first);
        if (first) begin
            m_ctrl = b;
            m_chan = b % 4;
        end else begin
            m_dac = b;
        end
    endtask

    task automatic model_read(output logic [7:0] b);
        b      = m_conv;
        m_conv = chan_val(ch_data, m_chan);
        if (m_ctrl[2]) m_chan = (m_chan + 1) % 4;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1; wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q);
        end
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        if (glitch) begin
            sda_m = ~b; wait_clk(1);
            sda_m = b;  wait_clk(Q - 1);
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_i;    wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic v;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(v);
            b = {b[6:0], v};
        end
        send_bit(~ack, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; ch_data = '0;
        dac_pulses = 0; dac_maxw = 0; dac_run = 0; oe_bad = 0; oe_on = 0;
        model_reset();
        wait_clk(5);
        nchecks++; if (sda_oe !== 1'b0) begin nfail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        nchecks++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nchecks++; if (dac_wr !== 1'b0) begin nfail++; $display("FAIL reset_dac_wr: got %b expected 0", dac_wr); end
        nchecks++; if (ctrl_reg !== 8'h00) begin nfail++; $display("FAIL reset_ctrl: got %h expected 00", ctrl_reg); end
        nchecks++; if (dac_data !== 8'h00) begin nfail++; $display("FAIL reset_dac: got %h expected 00", dac_data); end
        nchecks++; if (dut.state_q !== IDLE) begin nfail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        rst = 1'b0;
        wait_clk(20);
    endtask

    task automatic test_write_ctrl();
        logic a0, a1;
        dac_pulses = 0;
        bus_start();
        write_byte(8'h90, 1'b0, a0);
        nchecks++; if (busy !== 1'b1) begin nfail++; $display("FAIL wctrl_busy: got %b expected 1", busy); end
        write_byte(8'h04, 1'b0, a1);
        model_write(8'h04, 1'b1);
        bus_stop(); wait_clk(10);
        nchecks++; if (a0 !== 1'b1) begin nfail++; $display("FAIL wctrl_addr_ack: got %b expected 1", a0); end
        nchecks++; if (a1 !== 1'b1) begin nfail++; $display("FAIL wctrl_data_ack: got %b expected 1", a1); end
        nchecks++; if (ctrl_reg !== 8'h04) begin nfail++; $display("FAIL wctrl_ctrl: got %h expected 04", ctrl_reg); end
        nchecks++; if (dac_pulses !== 0) begin nfail++; $display("FAIL wctrl_dac_wr: got %0d pulses expected 0", dac_pulses); end
        nchecks++; if (busy !== 1'b0) begin nfail++; $display("FAIL wctrl_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_write_dac();
        logic a0, a1, a2;
        dac_pulses = 0; dac_maxw = 0;
        bus_start();
        write_byte(8'h90, 1'b0, a0);
        write_byte(8'h41, 1'b0, a1); model_write(8'h41, 1'b1);
        write_byte(8'h5A, 1'b0, a2); model_write(8'h5A, 1'b0);
        bus_stop(); wait_clk(10);
        nchecks++; if ({a0, a1, a2} !== 3'b111) begin nfail++; $display("FAIL wdac_acks: got %b expected 111", {a0, a1, a2}); end
        nchecks++; if (dac_data !== 8'h5A) begin nfail++; $display("FAIL wdac_data: got %h expected 5a", dac_data); end
        nchecks++; if (dac_pulses !== 1) begin nfail++; $display("FAIL wdac_pulses: got %0d expected 1", dac_pulses); end
        nchecks++; if (dac_maxw !== 1) begin nfail++; $display("FAIL wdac_width: got %0d expected 1", dac_maxw); end
        nchecks++; if (ctrl_reg !== m_ctrl) begin nfail++; $display("FAIL wdac_ctrl: got %h expected %h", ctrl_reg, m_ctrl); end
    endtask

    task automatic test_read_seq();
        logic a;
        logic [7:0] got, exp;
        logic [7:0] fixed [5];
        fixed[0] = 8'h80; fixed[1] = 8'h80; fixed[2] = 8'hA0; fixed[3] = 8'h40; fixed[4] = 8'hFF;
        ch_data = 32'hFF40_A080;
        bus_start();
        write_byte(8'h90, 1'b0, a);
        write_byte(8'h04, 1'b0, a); model_write(8'h04, 1'b1);
        bus_stop();
        bus_start();
        write_byte(8'h91, 1'b0, a);
        nchecks++; if (a !== 1'b1) begin nfail++; $display("FAIL rseq_addr_ack: got %b expected 1", a); end
        for (int i = 0; i < 5; i++) begin
            model_read(exp);
            read_byte(got, i != 4);
            nchecks++; if (got !== exp || got !== fixed[i]) begin nfail++; $display("FAIL rseq_byte%0d: got %h expected %h", i, got, fixed[i]); end
        end
        wait_clk(2);
        nchecks++; if (sda_oe !== 1'b0) begin nfail++; $display("FAIL rseq_oe_after_nack: got %b expected 0", sda_oe); end
        nchecks++; if (dut.state_q !== IGNORE) begin nfail++; $display("FAIL rseq_state_nack: got %0d expected %0d", dut.state_q, IGNORE); end
        bus_stop(); wait_clk(10);
    endtask

    task automatic test_bad_addr();
        logic a;
        logic [7:0] ctrl_before;
        ctrl_before = m_ctrl;
        oe_on = 0;
        bus_start();
        write_byte(8'h92, 1'b0, a);
        nchecks++; if (a !== 1'b0) begin nfail++; $display("FAIL bad_addr_ack: got %b expected 0", a); end
        nchecks++; if (dut.state_q !== IGNORE) begin nfail++; $display("FAIL bad_addr_state: got %0d expected %0d", dut.state_q, IGNORE); end
        write_byte(8'h07, 1'b0, a);
        nchecks++; if (dut.state_q !== IGNORE) begin nfail++; $display("FAIL bad_addr_state2: got %0d expected %0d", dut.state_q, IGNORE); end
        bus_stop(); wait_clk(10);
        nchecks++; if (oe_on !== 0) begin nfail++; $display("FAIL bad_addr_oe: got %0d driven cycles expected 0", oe_on); end
        nchecks++; if (ctrl_reg !== ctrl_before) begin nfail++; $display("FAIL bad_addr_ctrl: got %h expected %h", ctrl_reg, ctrl_before); end
        nchecks++; if (dut.state_q !== IDLE) begin nfail++; $display("FAIL bad_addr_stop: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_repeated_start();
        logic a;
        logic [7:0] got, exp;
        ch_data = $urandom;
        bus_start();
        write_byte(8'h90, 1'b0, a);
        write_byte(8'h03, 1'b0, a); model_write(8'h03, 1'b1);
        bus_start();
        write_byte(8'h91, 1'b0, a);
        nchecks++; if (a !== 1'b1) begin nfail++; $display("FAIL rstart_ack: got %b expected 1", a); end
        model_read(exp);
        read_byte(got, 1'b1);
        nchecks++; if (got !== exp) begin nfail++; $display("FAIL rstart_byte1: got %h expected %h", got, exp); end
        model_read(exp);
        read_byte(got, 1'b0);
        nchecks++; if (got !== exp || got !== ch_data[31:24]) begin nfail++; $display("FAIL rstart_byte2: got %h expected %h", got, ch_data[31:24]); end
        bus_stop(); wait_clk(10);
    endtask

    task automatic test_glitch();
        logic a0, a1;
        sda_m = 1'b0; wait_clk(1); sda_m = 1'b1;
        wait_clk(20);
        nchecks++; if (dut.state_q !== IDLE) begin nfail++; $display("FAIL glitch_idle: got %0d expected %0d", dut.state_q, IDLE); end
        bus_start();
        write_byte(8'h90, 1'b0, a0);
        write_byte(8'h15, 1'b1, a1); model_write(8'h15, 1'b1);
        nchecks++; if (busy !== 1'b1) begin nfail++; $display("FAIL glitch_busy: got %b expected 1", busy); end
        nchecks++; if ({a0, a1} !== 2'b11) begin nfail++; $display("FAIL glitch_acks: got %b expected 11", {a0, a1}); end
        nchecks++; if (ctrl_reg !== 8'h15) begin nfail++; $display("FAIL glitch_ctrl: got %h expected 15", ctrl_reg); end
        bus_stop(); wait_clk(10);
    endtask

    task automatic test_reset_mid_read();
        logic a;
        logic [7:0] got, exp;
        ch_data = 32'h0000_0000;
        bus_start();
        write_byte(8'h90, 1'b0, a);
        write_byte(8'h00, 1'b0, a); model_write(8'h00, 1'b1);
        bus_start();
        write_byte(8'h91, 1'b0, a);
        model_read(exp);
        read_byte(got, 1'b0);
        bus_stop();
        bus_start();
        write_byte(8'h91, 1'b0, a);
        nchecks++; if (sda_oe !== 1'b1) begin nfail++; $display("FAIL rst_pre_oe: got %b expected 1", sda_oe); end
        #3 rst = 1'b1;
        #1;
        nchecks++; if (sda_oe !== 1'b0) begin nfail++; $display("FAIL rst_async_oe: got %b expected 0", sda_oe); end
        wait_clk(1);
        nchecks++; if (dut.state_q !== IDLE) begin nfail++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, IDLE); end
        nchecks++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        model_reset();
        wait_clk(20);
        nchecks++; if (ctrl_reg !== 8'h00) begin nfail++; $display("FAIL rst_ctrl: got %h expected 00", ctrl_reg); end
        ch_data = $urandom;
        bus_start();
        write_byte(8'h91, 1'b0, a);
        model_read(exp);
        read_byte(got, 1'b0);
        bus_stop(); wait_clk(10);
        nchecks++; if (got !== exp) begin nfail++; $display("FAIL rst_conv_reset: got %h expected %h", got, exp); end
    endtask

    task automatic test_random();
        logic a;
        logic [7:0] b, got, exp;
        logic [6:0] addr;
        int kind, n, exp_pulses;
        for (int t = 0; t < 14; t++) begin
            ch_data = $urandom;
            kind = $urandom_range(0, 2);
            dac_pulses = 0;
            bus_start();
            if (kind == 0) begin
                n = $urandom_range(0, 4);
                exp_pulses = (n > 1) ? n - 1 : 0;
                write_byte(8'h90, 1'b0, a);
                nchecks++; if (a !== 1'b1) begin nfail++; $display("FAIL rnd%0d_waddr_ack: got %b expected 1", t, a); end
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    write_byte(b, 1'b0, a);
                    model_write(b, i == 0);
                    nchecks++; if (a !== 1'b1) begin nfail++; $display("FAIL rnd%0d_wdata_ack%0d: got %b expected 1", t, i, a); end
                end
                bus_stop(); wait_clk(10);
                nchecks++; if (ctrl_reg !== m_ctrl) begin nfail++; $display("FAIL rnd%0d_ctrl: got %h expected %h", t, ctrl_reg, m_ctrl); end
                nchecks++; if (dac_data !== m_dac) begin nfail++; $display("FAIL rnd%0d_dac: got %h expected %h", t, dac_data, m_dac); end
                nchecks++; if (dac_pulses !== exp_pulses) begin nfail++; $display("FAIL rnd%0d_dac_wr: got %0d expected %0d", t, dac_pulses, exp_pulses); end
            end else if (kind == 1) begin
                n = $urandom_range(1, 5);
                write_byte(8'h91, 1'b0, a);
                nchecks++; if (a !== 1'b1) begin nfail++; $display("FAIL rnd%0d_raddr_ack: got %b expected 1", t, a); end
                for (int i = 0; i < n; i++) begin
                    model_read(exp);
                    read_byte(got, i != n - 1);
                    nchecks++; if (got !== exp) begin nfail++; $display("FAIL rnd%0d_rbyte%0d: got %h expected %h", t, i, got, exp); end
                end
                bus_stop(); wait_clk(10);
            end else begin
                addr = 7'($urandom_range(0, 127));
                if (addr == 7'h48) addr = 7'h49;
                write_byte({addr, 1'($urandom_range(0, 1))}, 1'b0, a);
                nchecks++; if (a !== 1'b0) begin nfail++; $display("FAIL rnd%0d_foreign_ack: got %b expected 0", t, a); end
                bus_stop(); wait_clk(10);
                nchecks++; if (ctrl_reg !== m_ctrl) begin nfail++; $display("FAIL rnd%0d_foreign_ctrl: got %h expected %h", t, ctrl_reg, m_ctrl); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_ctrl();
        test_write_dac();
        test_read_seq();
        test_bad_addr();
        test_repeated_start();
        test_glitch();
        test_random();
        test_reset_mid_read();
        nchecks++; if (oe_bad !== 0) begin nfail++; $display("FAIL oe_edge_timing: got %0d changes with SCL high expected 0", oe_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
